// File: rtl/l1_axi_responder_pkg.sv
// Shared types and constants for the L1 AXI responder: response codes, FSM state
// enums and the per-beat address check.
package l1_axi_responder_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [2:0] AXI_SIZE_WORD   = 3'b010;

  typedef enum logic       {R_IDLE, R_DATA}         l1_rd_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} l1_wr_state_t;

  // An address is bad if it is unaligned or at/above the end of backing memory.
  function automatic logic addr_err(input logic [31:0] addr, input logic [32:0] mem_bytes);
    return ({1'b0, addr} >= mem_bytes) || (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/l1_axi_responder_if.sv
// AXI4 bundle for the per-core L1 port; the responder uses the slave modport.
// Handshakes: a transfer happens on a rising edge where VALID and READY are both 1;
// a source holds VALID and its payload stable until the transfer.
interface l1_axi_responder_if;
  logic        arvalid, arready;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic        rvalid, rready;
  logic [31:0] rdata;
  logic        rlast;
  logic        rid;
  logic [1:0]  rresp;
  logic        awvalid, awready;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        bvalid, bready;
  logic [1:0]  bresp;
  logic        bid;

  modport slave (
    input  arvalid, araddr, arlen, arsize, rready,
           awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rlast, rid, rresp,
           awready, wready, bvalid, bresp, bid
  );

  modport master (
    output arvalid, araddr, arlen, arsize, rready,
           awvalid, awaddr, awlen, awsize, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rlast, rid, rresp,
           awready, wready, bvalid, bresp, bid
  );
endinterface

// File: rtl/l1_axi_responder_ram_1r1w.sv
// Simple dual-port RAM: one registered read port (read-first, holds when re=0)
// and one byte-enabled write port.
module l1_ram_1r1w #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wbe
);
  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q, rdata_d;

  // Sampling mem before its NBA update gives old data on a same-address collision.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    rdata_q <= rdata_d;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/l1_axi_responder.sv
// AXI4 slave backing a word-addressed local memory; independent read and write
// FSMs with per-beat SLVERR on out-of-range, unaligned or non-word-size beats.
module l1_axi_responder
  import l1_axi_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_BITS   = $clog2(DEPTH_WORDS)
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  l1_axi_responder_if.slave  s_axi_l1_V,
  output l1_rd_state_t       dbg_rd_state,
  output l1_wr_state_t       dbg_wr_state
);
  localparam logic [32:0] MEM_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  l1_rd_state_t rd_state_q, rd_state_d;
  logic [31:0]  rd_addr_q, rd_addr_d;
  logic [7:0]   rd_rem_q, rd_rem_d;
  logic         rd_size_err_q, rd_size_err_d;
  logic         rd_err_q, rd_err_d;

  l1_wr_state_t wr_state_q, wr_state_d;
  logic [31:0]  wr_addr_q, wr_addr_d;
  logic         wr_size_err_q, wr_size_err_d;
  logic         wr_bresp_err_q, wr_bresp_err_d;
  logic         wr_beat_err;

  logic                 ram_re, ram_we;
  logic [ADDR_BITS-1:0] ram_raddr, ram_waddr;
  logic [31:0]          ram_rdata;

  // rd_addr_q always holds the address of the next beat to fetch.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_addr_d     = rd_addr_q;
    rd_rem_d      = rd_rem_q;
    rd_size_err_d = rd_size_err_q;
    rd_err_d      = rd_err_q;
    ram_re        = 1'b0;
    ram_raddr     = s_axi_l1_V.araddr[ADDR_BITS+1:2];
    case (rd_state_q)
      R_IDLE: begin
        if (s_axi_l1_V.arvalid) begin
          ram_re        = 1'b1;
          rd_addr_d     = s_axi_l1_V.araddr + 32'd4;
          rd_rem_d      = s_axi_l1_V.arlen;
          rd_size_err_d = (s_axi_l1_V.arsize != AXI_SIZE_WORD);
          rd_err_d      = addr_err(s_axi_l1_V.araddr, MEM_BYTES) ||
                          (s_axi_l1_V.arsize != AXI_SIZE_WORD);
          rd_state_d    = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_l1_V.rready) begin
          if (rd_rem_q == 8'd0) begin
            rd_state_d = R_IDLE;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = rd_addr_q[ADDR_BITS+1:2];
            rd_err_d  = addr_err(rd_addr_q, MEM_BYTES) || rd_size_err_q;
            rd_addr_d = rd_addr_q + 32'd4;
            rd_rem_d  = rd_rem_q - 8'd1;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    wr_state_d     = wr_state_q;
    wr_addr_d      = wr_addr_q;
    wr_size_err_d  = wr_size_err_q;
    wr_bresp_err_d = wr_bresp_err_q;
    ram_we         = 1'b0;
    ram_waddr      = wr_addr_q[ADDR_BITS+1:2];
    wr_beat_err    = addr_err(wr_addr_q, MEM_BYTES) || wr_size_err_q;
    case (wr_state_q)
      W_IDLE: begin
        if (s_axi_l1_V.awvalid) begin
          wr_size_err_d = (s_axi_l1_V.awsize != AXI_SIZE_WORD);
          if (s_axi_l1_V.wvalid) begin
            wr_beat_err    = addr_err(s_axi_l1_V.awaddr, MEM_BYTES) ||
                             (s_axi_l1_V.awsize != AXI_SIZE_WORD);
            ram_waddr      = s_axi_l1_V.awaddr[ADDR_BITS+1:2];
            ram_we         = !wr_beat_err;
            wr_bresp_err_d = wr_beat_err;
            wr_addr_d      = s_axi_l1_V.awaddr + 32'd4;
            wr_state_d     = s_axi_l1_V.wlast ? W_RESP : W_DATA;
          end else begin
            wr_bresp_err_d = 1'b0;
            wr_addr_d      = s_axi_l1_V.awaddr;
            wr_state_d     = W_DATA;
          end
        end
      end
      W_DATA: begin
        if (s_axi_l1_V.wvalid) begin
          ram_we         = !wr_beat_err;
          wr_bresp_err_d = wr_bresp_err_q || wr_beat_err;
          wr_addr_d      = wr_addr_q + 32'd4;
          if (s_axi_l1_V.wlast) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_l1_V.bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rd_state_q     <= R_IDLE;
      rd_addr_q      <= '0;
      rd_rem_q       <= '0;
      rd_size_err_q  <= 1'b0;
      rd_err_q       <= 1'b0;
      wr_state_q     <= W_IDLE;
      wr_addr_q      <= '0;
      wr_size_err_q  <= 1'b0;
      wr_bresp_err_q <= 1'b0;
    end else begin
      rd_state_q     <= rd_state_d;
      rd_addr_q      <= rd_addr_d;
      rd_rem_q       <= rd_rem_d;
      rd_size_err_q  <= rd_size_err_d;
      rd_err_q       <= rd_err_d;
      wr_state_q     <= wr_state_d;
      wr_addr_q      <= wr_addr_d;
      wr_size_err_q  <= wr_size_err_d;
      wr_bresp_err_q <= wr_bresp_err_d;
    end
  end

  l1_ram_1r1w #(.DEPTH(DEPTH_WORDS), .AW(ADDR_BITS)) u_ram (
    .clk   (ap_clk),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (s_axi_l1_V.wdata),
    .wbe   (s_axi_l1_V.wstrb)
  );

  // RDATA is masked outside a valid OKAY beat so reset and error beats read as 0.
  assign s_axi_l1_V.arready = (rd_state_q == R_IDLE);
  assign s_axi_l1_V.rvalid  = (rd_state_q == R_DATA);
  assign s_axi_l1_V.rlast   = (rd_state_q == R_DATA) && (rd_rem_q == 8'd0);
  assign s_axi_l1_V.rresp   = ((rd_state_q == R_DATA) && rd_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_l1_V.rdata   = ((rd_state_q == R_DATA) && !rd_err_q) ? ram_rdata : 32'd0;
  assign s_axi_l1_V.rid     = 1'b0;

  assign s_axi_l1_V.awready = (wr_state_q == W_IDLE);
  assign s_axi_l1_V.wready  = ((wr_state_q == W_IDLE) && s_axi_l1_V.awvalid) ||
                              (wr_state_q == W_DATA);
  assign s_axi_l1_V.bvalid  = (wr_state_q == W_RESP);
  assign s_axi_l1_V.bresp   = ((wr_state_q == W_RESP) && wr_bresp_err_q) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign s_axi_l1_V.bid     = 1'b0;

  assign dbg_rd_state = rd_state_q;
  assign dbg_wr_state = wr_state_q;
endmodule

// File: tb/tb_l1_axi_responder.sv
// Randomized bench for l1_axi_responder against a word-array memory model and
// expected-beat queues, plus directed cases with literal expectations.
module tb_l1_axi_responder;
  import l1_axi_responder_pkg::*;

  localparam int DEPTH = 256;
  localparam logic [31:0] MEM_TOP = 32'd1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  l1_axi_responder_if axi();
  l1_rd_state_t dbg_rd_state;
  l1_wr_state_t dbg_wr_state;

  l1_axi_responder #(.DEPTH_WORDS(DEPTH), .ADDR_BITS(8)) dut (
    .ap_clk       (clk),
    .ap_rst_n     (rst_n),
    .s_axi_l1_V   (axi),
    .dbg_rd_state (dbg_rd_state),
    .dbg_wr_state (dbg_wr_state)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_mem [DEPTH];
  logic [34:0] exp_q[$];     // {rlast, rresp, rdata}
  logic [1:0]  exp_b_q[$];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];
  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;
  logic [1:0]  last_bresp;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic beat_bad(input logic [31:0] a, input logic [2:0] size);
    return (a >= MEM_TOP) || (a % 4 != 0) || (size != 3'b010);
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic        stall_prev = 1'b0;
  logic [34:0] prev_beat;
  always begin
    @(negedge clk);
    #3;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("r_hold", {axi.rvalid, axi.rlast, axi.rresp, axi.rdata}, {1'b1, prev_beat});
      if (axi.rvalid) begin
        check("ar_busy", axi.arready, 1'b0);
        if (axi.rready) begin
          if (exp_q.size() == 0) check("r_unexpected", 1, 0);
          else check("r_beat", {axi.rlast, axi.rresp, axi.rdata}, exp_q.pop_front());
          last_rdata = axi.rdata;
          last_rresp = axi.rresp;
        end
      end
      stall_prev = axi.rvalid && !axi.rready;
      prev_beat  = {axi.rlast, axi.rresp, axi.rdata};
      if (axi.bvalid && axi.bready) begin
        if (exp_b_q.size() == 0) check("b_unexpected", 1, 0);
        else check("b_resp", axi.bresp, exp_b_q.pop_front());
        last_bresp = axi.bresp;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // stall_mode: 0 always ready, 1 pattern 1,0,0,1,0,0..., 2 random
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input int stall_mode);
    int budget, k, cyc;
    logic [31:0] a;
    @(negedge clk);
    axi.arvalid = 1'b1; axi.araddr = addr; axi.arlen = len; axi.arsize = size;
    #1;
    budget = 0;
    while (!axi.arready && budget < 100) begin @(negedge clk); #1; budget++; end
    if (!axi.arready) begin check("ar_timeout", 0, 1); axi.arvalid = 1'b0; return; end
    @(posedge clk);
    for (int i = 0; i <= int'(len); i++) begin
      a = addr + 32'(i) * 32'd4;
      if (beat_bad(a, size)) exp_q.push_back({(i == int'(len)), AXI_RESP_SLVERR, 32'd0});
      else exp_q.push_back({(i == int'(len)), AXI_RESP_OKAY, model_mem[a[9:2]]});
    end
    @(negedge clk);
    axi.arvalid = 1'b0;
    #1 check("r_latency", axi.rvalid, 1'b1);
    k = 0; cyc = 0;
    while (k <= int'(len) && cyc < 2000) begin
      case (stall_mode)
        0: axi.rready = 1'b1;
        1: axi.rready = (cyc % 3 == 0);
        default: axi.rready = ($urandom_range(0, 2) != 0);
      endcase
      #1;
      if (axi.rvalid && axi.rready) k++;
      @(negedge clk);
      cyc++;
    end
    axi.rready = 1'b0;
    if (k <= int'(len)) check("r_timeout", 0, 1);
  endtask

  task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                           input bit together, input int bdelay);
    int budget, k, cyc;
    logic any_bad;
    logic [31:0] a;
    any_bad = 1'b0;
    for (int i = 0; i <= len; i++) if (beat_bad(addr + 32'(i) * 32'd4, size)) any_bad = 1'b1;
    exp_b_q.push_back(any_bad ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
    @(negedge clk);
    axi.awvalid = 1'b1; axi.awaddr = addr; axi.awlen = 8'(len); axi.awsize = size;
    if (together) begin
      axi.wvalid = 1'b1; axi.wdata = wbuf[0]; axi.wstrb = sbuf[0]; axi.wlast = (len == 0);
    end
    #1;
    budget = 0;
    while (!axi.awready && budget < 100) begin @(negedge clk); #1; budget++; end
    if (!axi.awready) begin check("aw_timeout", 0, 1); axi.awvalid = 1'b0; axi.wvalid = 1'b0; return; end
    if (together) check("aw_w_same", {axi.awready, axi.wready}, 2'b11);
    @(posedge clk);
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    k = together ? 1 : 0; cyc = 0;
    while (k <= len && cyc < 4000) begin
      if ($urandom_range(0, 3) != 0) begin
        axi.wvalid = 1'b1; axi.wdata = wbuf[k]; axi.wstrb = sbuf[k]; axi.wlast = (k == len);
      end else axi.wvalid = 1'b0;
      #1;
      if (axi.wvalid && axi.wready) k++;
      @(negedge clk);
      cyc++;
    end
    axi.wvalid = 1'b0; axi.wlast = 1'b0;
    if (k <= len) check("w_timeout", 0, 1);
    #1 check("b_early", axi.bvalid, 1'b1);
    repeat (bdelay) @(negedge clk);
    axi.bready = 1'b1;
    #1;
    budget = 0;
    while (!axi.bvalid && budget < 100) begin @(negedge clk); #1; budget++; end
    if (!axi.bvalid) check("b_timeout", 0, 1);
    @(negedge clk);
    axi.bready = 1'b0;
    for (int i = 0; i <= len; i++) begin
      a = addr + 32'(i) * 32'd4;
      if (!beat_bad(a, size))
        for (int b = 0; b < 4; b++)
          if (sbuf[i][b]) model_mem[a[9:2]][8*b +: 8] = wbuf[i][8*b +: 8];
    end
  endtask

  task automatic write1(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    wbuf[0] = data; sbuf[0] = strb;
    axi_write(addr, 0, 3'b010, 1'b1, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    axi.arvalid = 0; axi.araddr = 0; axi.arlen = 0; axi.arsize = 3'b010; axi.rready = 0;
    axi.awvalid = 0; axi.awaddr = 0; axi.awlen = 0; axi.awsize = 3'b010;
    axi.wvalid = 0; axi.wdata = 0; axi.wstrb = 0; axi.wlast = 0; axi.bready = 0;
    #12;
    check("rst_ready", {axi.arready, axi.awready}, 2'b11);
    check("rst_valid", {axi.rvalid, axi.rlast, axi.bvalid}, 3'b000);
    check("rst_resp_data", {axi.rresp, axi.bresp, axi.rdata}, 36'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fill the whole memory so every model word is defined
    for (int i = 0; i < 256; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    axi_write(32'h0, 255, 3'b010, 1'b0, 0);

    write1(32'h10, 32'hDEADBEEF, 4'hF);
    check("lit_bresp_ok", last_bresp, 2'b00);
    axi_read(32'h10, 0, 3'b010, 0);
    check("lit_dead", last_rdata, 32'hDEADBEEF);
    write1(32'h10, 32'h0000FFFF, 4'h3);
    check("lit_model_strb", model_mem[4], 32'hDEADFFFF);
    axi_read(32'h10, 0, 3'b010, 0);
    check("lit_strb", last_rdata, 32'hDEADFFFF);

    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'(i + 1); sbuf[i] = 4'hF; end
    axi_write(32'h40, 3, 3'b010, 1'b1, 1);
    axi_read(32'h40, 3, 3'b010, 1);
    check("lit_burst_last", last_rdata, 32'd4);

    write1(32'h0, 32'hA5A5A5A5, 4'hF);
    axi_read(MEM_TOP, 0, 3'b010, 0);
    check("lit_top_rd", {last_rresp, last_rdata}, {2'b10, 32'd0});
    write1(MEM_TOP, 32'h12345678, 4'hF);
    check("lit_top_wr", last_bresp, 2'b10);
    axi_read(32'h0, 0, 3'b010, 0);
    check("lit_no_alias", last_rdata, 32'hA5A5A5A5);

    write1(32'h20, 32'd5, 4'hF);
    fork
      write1(32'h20, 32'd9, 4'hF);
      axi_read(32'h20, 0, 3'b010, 0);
    join
    check("lit_read_first", last_rdata, 32'd5);
    axi_read(32'h20, 0, 3'b010, 2);
    check("lit_after_write", last_rdata, 32'd9);

    // reset during beat 2 of an 8-beat burst
    @(negedge clk);
    axi.arvalid = 1'b1; axi.araddr = 32'h40; axi.arlen = 8'd7; axi.arsize = 3'b010;
    @(posedge clk);
    for (int i = 0; i < 8; i++) exp_q.push_back({(i == 7), AXI_RESP_OKAY, model_mem[16 + i]});
    @(negedge clk);
    axi.arvalid = 1'b0; axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_rvalid", axi.rvalid, 1'b0);
    check("rst_rd_state", dbg_rd_state, R_IDLE);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst_arready", axi.arready, 1'b1);
    axi_read(32'h40, 3, 3'b010, 0);
    check("lit_after_rst", last_rdata, 32'd4);

    // randomized traffic
    for (int it = 0; it < 60; it++) begin
      logic [31:0] addr;
      logic [2:0]  size;
      int          region, len;
      region = $urandom_range(0, 9);
      len    = $urandom_range(0, 7);
      size   = ($urandom_range(0, 15) == 0) ? 3'b001 : 3'b010;
      case (region)
        7: addr = MEM_TOP - 32'($urandom_range(0, 3)) * 32'd4;
        8: addr = 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(1, 3));
        9: addr = 32'hFFFF_FFF8;
        default: addr = 32'($urandom_range(0, 255 - len)) * 32'd4;
      endcase
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i <= len; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom_range(0, 15)); end
        axi_write(addr, len, size, 1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end else begin
        axi_read(addr, 8'(len), size, $urandom_range(0, 2));
      end
    end

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("exp_b_q_drained", exp_b_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog");
  end
endmodule
